// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops one word from the transmit FIFO whenever it is
// non-empty and drain is enabled, then serialises it onto a UART TX line
// as start bit, WIDTH data bits LSB first, optional even parity, stop bit.
module fifo_uart_drain #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [15:0]        r_baud;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [WIDTH-1:0]   r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_fifo_rd;
  logic               r_busy;
  logic [15:0]        r_frames_sent;

  logic               w_baud_done;
  logic               w_last_bit;
  logic [WIDTH-1:0]   w_shift_next;

  assign w_baud_done  = (r_baud == 16'(CLKS_PER_BIT - 1));
  assign w_last_bit   = (r_bit_idx == IDX_W'(WIDTH - 1));
  assign w_shift_next = r_shift >> 1;

  assign fifo_rd     = r_fifo_rd;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign frames_sent = r_frames_sent;

  // Frame sequencer; tx/busy/fifo_rd are registered and set on the
  // transition into the state they belong to, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_baud        <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_tx          <= 1'b1;
      r_fifo_rd     <= 1'b0;
      r_busy        <= 1'b0;
      r_frames_sent <= '0;
    end else begin
      r_fifo_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && !fifo_empty) begin
            r_state   <= S_FETCH;
            r_fifo_rd <= 1'b1;
            r_busy    <= 1'b1;
            r_baud    <= '0;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
          r_baud  <= '0;
        end
        S_LOAD: begin
          r_shift  <= fifo_data;
          r_parity <= ^fifo_data;
          r_tx     <= 1'b0;
          r_state  <= S_START;
          r_baud   <= '0;
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            if (w_last_bit) begin
              r_bit_idx <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_tx      <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud        <= '0;
            r_busy        <= 1'b0;
            r_frames_sent <= r_frames_sent + 16'd1;
            r_state       <= S_IDLE;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: two instances (no parity / even parity) share
// clock, reset and enable; each has its own FIFO model. Pops push expected
// frames into a scoreboard; a UART-receiver monitor per lane checks tx.
module tb_fifo_uart_drain;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] d;
    int         st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        empty   [2];
  logic [7:0]  rdata   [2];
  logic        rd_w    [2];
  logic        tx_w    [2];
  logic        busy_w  [2];
  logic [15:0] fs_w    [2];

  logic [7:0]  fq      [2][$];
  exp_t        exq     [2][$];
  int          popc    [2][$];
  int          pops    [2];
  bit          prev_rd [2];
  bit          inframe [2];
  logic [15:0] exp_cnt [2];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(empty[0]),
    .fifo_data(rdata[0]), .fifo_rd(rd_w[0]), .tx(tx_w[0]),
    .busy(busy_w[0]), .frames_sent(fs_w[0])
  );

  fifo_uart_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(empty[1]),
    .fifo_data(rdata[1]), .fifo_rd(rd_w[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .frames_sent(fs_w[1])
  );

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // FIFO read-port model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd_w[g]) begin
        total++;
        if (fq[g].size() == 0 || prev_rd[g]) begin
          bad++;
          $display("FAIL pop_check lane%0d: fifo_rd with empty=%0d repeat=%0d", g,
                   fq[g].size() == 0, prev_rd[g]);
        end else begin
          exp_t e;
          e.d  = fq[g].pop_front();
          e.st = cyc + 2;
          rdata[g] <= e.d;
          exq[g].push_back(e);
          popc[g].push_back(cyc);
          pops[g]++;
        end
      end
      prev_rd[g] = rd_w[g];
      empty[g] <= (fq[g].size() == 0);
    end
  end

  // UART receiver: every cycle of every bit period must carry the expected level.
  task automatic mon(input int g);
    exp_t       e;
    logic [11:0] fr;
    int         nb;
    bit         err, aborted;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exq[g].delete();
        exp_cnt[g] = '0;
        inframe[g] = 1'b0;
      end else if (tx_w[g] == 1'b0) begin
        inframe[g] = 1'b1;
        if (exq[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start lane%0d at cycle %0d", g, cyc);
        end else begin
          e = exq[g].pop_front();
          chk($sformatf("start_cycle lane%0d", g), cyc, e.st);
          chk($sformatf("busy_in_frame lane%0d", g), busy_w[g], 1);
          nb = 10 + g;
          fr = '1;
          fr[0] = 1'b0;
          for (int i = 0; i < 8; i++) fr[i+1] = e.d[i];
          if (g == 1) fr[9] = ($countones(e.d) % 2 == 1);
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            err = 1'b0;
            for (int c = 0; c < CPB && !aborted; c++) begin
              if (b != 0 || c != 0) begin
                @(negedge clk);
                if (!rst_n) aborted = 1'b1;
              end
              if (!aborted && tx_w[g] != fr[b]) err = 1'b1;
            end
            if (!aborted) begin
              total++;
              if (err) begin
                bad++;
                $display("FAIL frame_bit lane%0d data=%02h bit=%0d: got other than required %0b",
                         g, e.d, b, fr[b]);
              end
            end
          end
          if (aborted) begin
            exq[g].delete();
            exp_cnt[g] = '0;
          end else begin
            @(negedge clk);
            if (!rst_n) begin
              exq[g].delete();
              exp_cnt[g] = '0;
            end else begin
              exp_cnt[g] = exp_cnt[g] + 16'd1;
              chk($sformatf("frames_sent lane%0d", g), fs_w[g], exp_cnt[g]);
              chk($sformatf("busy_after_stop lane%0d", g), busy_w[g], 0);
            end
          end
        end
        inframe[g] = 1'b0;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] v);
    for (int g = 0; g < 2; g++) fq[g].push_back(v);
  endtask

  function automatic bit lanes_idle();
    bit ok = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if (busy_w[g] || inframe[g] || exq[g].size() != 0 || (fq[g].size() != 0 && en))
        ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (lanes_idle()) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_%s: lanes still busy after 3000 cycles", nm);
  endtask

  task automatic wait_pop(input string nm, input int p);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (pops[0] > p) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_%s: no fifo_rd within 200 cycles", nm);
  endtask

  initial begin
    int p0 [2];
    int f0 [2];
    rst_n = 1'b0;
    en    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      empty[g]   = 1'b1;
      rdata[g]   = '0;
      pops[g]    = 0;
      exp_cnt[g] = '0;
    end
    step(3);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_tx lane%0d", g), tx_w[g], 1);
      chk($sformatf("rst_busy lane%0d", g), busy_w[g], 0);
      chk($sformatf("rst_fifo_rd lane%0d", g), rd_w[g], 0);
      chk($sformatf("rst_frames lane%0d", g), fs_w[g], 0);
    end
    rst_n = 1'b1;
    step(2);

    // Basic frame and parity frames
    en = 1'b1;
    for (int g = 0; g < 2; g++) p0[g] = pops[g];
    push(8'hA5);
    wait_idle("basic");
    for (int g = 0; g < 2; g++) chk($sformatf("basic_pops lane%0d", g), pops[g] - p0[g], 1);
    push(8'h07);
    push(8'h03);
    wait_idle("parity");

    // Burst of three back-to-back words
    for (int g = 0; g < 2; g++) begin
      popc[g].delete();
      f0[g] = fs_w[g];
    end
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_idle("burst");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("burst_pops lane%0d", g), popc[g].size(), 3);
      if (popc[g].size() == 3) begin
        chk($sformatf("burst_gap1 lane%0d", g), popc[g][1] - popc[g][0], (10 + g) * CPB + 3);
        chk($sformatf("burst_gap2 lane%0d", g), popc[g][2] - popc[g][1], (10 + g) * CPB + 3);
      end
      chk($sformatf("burst_frames lane%0d", g), fs_w[g] - f0[g], 3);
    end

    // Enable gating with a non-empty FIFO
    en = 1'b0;
    for (int g = 0; g < 2; g++) p0[g] = pops[g];
    push(8'h3C);
    step(100);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("gate_pops lane%0d", g), pops[g] - p0[g], 0);
      chk($sformatf("gate_tx lane%0d", g), tx_w[g], 1);
    end
    en = 1'b1;
    wait_idle("gate_release");

    // Drop en mid-DATA: current frame finishes, nothing further is fetched
    for (int g = 0; g < 2; g++) p0[g] = pops[g];
    push(8'h5A);
    push(8'hC3);
    wait_pop("endrop", p0[0]);
    step(10);
    en = 1'b0;
    wait_idle("endrop");
    step(20);
    for (int g = 0; g < 2; g++) chk($sformatf("endrop_pops lane%0d", g), pops[g] - p0[g], 1);
    en = 1'b1;
    wait_idle("endrop_drain");

    // Reset during data bit 3; next word must go out whole
    for (int g = 0; g < 2; g++) p0[g] = pops[g];
    push(8'h11);
    push(8'hE7);
    wait_pop("rstmid", p0[0]);
    step(17);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rstmid_tx lane%0d", g), tx_w[g], 1);
      chk($sformatf("rstmid_busy lane%0d", g), busy_w[g], 0);
      chk($sformatf("rstmid_frames lane%0d", g), fs_w[g], 0);
    end
    step(1);
    rst_n = 1'b1;
    wait_idle("rstmid");
    for (int g = 0; g < 2; g++) chk($sformatf("rstmid_after lane%0d", g), fs_w[g], 1);

    // Randomised words at random spacing
    for (int i = 0; i < 24; i++) begin
      push(8'($urandom_range(0, 255)));
      step($urandom_range(0, 30));
    end
    wait_idle("random");

    // frames_sent wrap
    force u0.r_frames_sent = 16'hFFFF;
    force u1.r_frames_sent = 16'hFFFF;
    step(1);
    release u0.r_frames_sent;
    release u1.r_frames_sent;
    step(1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("wrap_preset lane%0d", g), fs_w[g], 16'hFFFF);
      exp_cnt[g] = 16'hFFFF;
    end
    push(8'h96);
    wait_idle("wrap");
    for (int g = 0; g < 2; g++) chk($sformatf("wrap_zero lane%0d", g), fs_w[g], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
